// File: rtl/data_sram_responder.sv
// ---------------------------------------------------------------------------
// data_sram_responder
//
// Purpose:
//   Data-memory responder on the far end of the core's data_sram interface.
//   EXE issues requests and MEM consumes data_sram_rdata one cycle later.
//   The block is a single-port word array with byte-lane writes and a
//   registered read port. Read data is held between accepted reads, so a
//   stalled MEM stage keeps seeing its load value. After reset a sequencer
//   zero-fills the whole array before any request is accepted.
//
// Ports:
//   clk              single clock, all state on posedge
//   reset            asynchronous, active-low; 0 clears all state immediately
//   data_sram_en     request valid this cycle
//   data_sram_we     byte write enables; 4'b0000 with en=1 is a read
//   data_sram_addr   byte address, bits [1:0] ignored
//   data_sram_wdata  write data, lane i = bits [8i+7:8i]
//   data_sram_rdata  registered read data, held until next accepted read
//   init_busy        1 while the zero-fill is in progress (requests ignored)
//   addr_err         one-cycle pulse the cycle after an out-of-range request
//   rd_cnt, wr_cnt   accepted in-range read / write counters
//                    (present only when DATA_SRAM_PERF_EN is defined)
//
// Optional feature macro: DATA_SRAM_PERF_EN
// ---------------------------------------------------------------------------
module data_sram_responder #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        init_busy,
`ifdef DATA_SRAM_PERF_EN
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt,
`endif
  output logic        addr_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [31:0]           rdata_q;
  logic                  addr_err_q;
  logic [31:0]           mem_q [DEPTH];

  logic [31:0]           off;
  logic                  in_range;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  req_ok;
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  unused_addr_bits;

  // Offset from the base with 32-bit wrap; an address below the base wraps to
  // a huge offset and so falls out of range naturally. In range means every
  // offset bit above the word index is zero.
  assign off              = data_sram_addr - BASE_ADDR;
  assign in_range         = (off[31:ADDR_WIDTH+2] == '0);
  assign idx              = off[ADDR_WIDTH+1:2];
  assign unused_addr_bits = ^off[1:0];

  assign req_ok = (state_q == READY) && data_sram_en;
  assign wr_ok  = req_ok && in_range && (data_sram_we != 4'b0000);
  assign rd_ok  = req_ok && in_range && (data_sram_we == 4'b0000);

  // State and fill-counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: INIT walks the counter over every word exactly once and
  // hands over to READY on the edge that clears the last word.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    init_busy = (state_q == INIT);
    if (state_q == INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
        state_d = READY;
      end
    end
  end

  // Array port. Not reset: contents are defined by the zero-fill pass.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      mem_q[cnt_q] <= 32'h0;
    end else if (wr_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_we[i]) begin
          mem_q[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
        end
      end
    end
  end

  // Read data register and error pulse. Bad reads return zero so MEM never
  // consumes stale data from an unrelated earlier load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q    <= 32'h0;
      addr_err_q <= 1'b0;
    end else begin
      addr_err_q <= req_ok && !in_range;
      if (rd_ok) begin
        rdata_q <= mem_q[idx];
      end else if (req_ok && !in_range && (data_sram_we == 4'b0000)) begin
        rdata_q <= 32'h0;
      end
    end
  end

  assign data_sram_rdata = rdata_q;
  assign addr_err        = addr_err_q;

`ifdef DATA_SRAM_PERF_EN
  logic [31:0] rd_cnt_q;
  logic [31:0] wr_cnt_q;

  // Accepted-request counters; they wrap freely.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_cnt_q <= 32'h0;
      wr_cnt_q <= 32'h0;
    end else begin
      if (rd_ok) rd_cnt_q <= rd_cnt_q + 32'd1;
      if (wr_ok) wr_cnt_q <= wr_cnt_q + 32'd1;
    end
  end

  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;
`endif

endmodule
